test_sequencer: RTL and testbench

Sequences one self-checking test on the single-cycle `processor`. It streams a program image, word by word, into the processor's byte-wide memory load port while holding the core in reset. It then releases the core, watches the `gp`/`a7`/`a0` verification taps for the end-of-test marker, and reports pass, fail or timeout. It sits between the host/testbench word source and the processor's `memEn`/`memAddr`/`memData`/`reset` pins.

---
 rtl/test_sequencer_if.sv | 38 +++
 rtl/test_sequencer.sv | 177 +++++++++++++++++
 tb/tb_test_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_sequencer_if.sv
// Bus between the test sequencer and its host plus the processor pins it drives.
// slave: the sequencer side; master: the host/testbench side.
interface test_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 14
);
  logic                 start;
  logic                 abort;
  logic [ADDR_BITS-2:0] num_words;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 mem_en;
  logic [WIDTH-1:0]     mem_addr;
  logic [WIDTH-1:0]     mem_data;
  logic                 cpu_reset;
  logic [WIDTH-1:0]     gp;
  logic [WIDTH-1:0]     a7;
  logic [WIDTH-1:0]     a0;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic [WIDTH-1:0]     fail_code;
  logic [31:0]          cycle_count;

  modport slave (
    input  start, abort, num_words, in_valid, in_data, gp, a7, a0,
    output in_ready, mem_en, mem_addr, mem_data, cpu_reset,
           busy, done, pass, timeout, fail_code, cycle_count
  );

  modport master (
    output start, abort, num_words, in_valid, in_data, gp, a7, a0,
    input  in_ready, mem_en, mem_addr, mem_data, cpu_reset,
           busy, done, pass, timeout, fail_code, cycle_count
  );
endinterface

// File: rtl/test_sequencer.sv
// Loads a program image byte-by-byte into the processor memory while the core
// is held in reset, releases it, and watches gp/a7/a0 for the end-of-test marker.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | core in reset, waiting for start
// S_LOAD   | accepting words, writing each as four byte cycles
// S_SETTLE | two cycles with mem_en low so the core reset sees a clean edge
// S_RUN    | core released, counting cycles, watching for end of test
// S_DONE   | core frozen, result held until next start
module test_sequencer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_BITS  = 14,
  parameter int BASE_ADDR  = 0,
  parameter int END_A7     = 93,
  parameter int MAX_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  test_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

  localparam int                   NW      = ADDR_BITS - 1;
  localparam logic [ADDR_BITS-1:0] LP_BASE = ADDR_BITS'(BASE_ADDR);
  localparam logic [WIDTH-1:0]     LP_END  = WIDTH'(END_A7);
  localparam logic [31:0]          LP_LAST = 32'(MAX_CYCLES - 1);

  state_t               r_state;
  logic [NW-1:0]        r_num_words;
  logic [NW-1:0]        r_words_acc;
  logic [ADDR_BITS-3:0] r_word_idx;
  logic [1:0]           r_byte_idx;
  logic [WIDTH-1:0]     r_buf;
  logic                 r_buf_valid;
  logic                 r_settle_cnt;
  logic                 r_armed;
  logic                 r_mem_en;
  logic [WIDTH-1:0]     r_mem_addr;
  logic [WIDTH-1:0]     r_mem_data;
  logic                 r_pass;
  logic                 r_timeout;
  logic [WIDTH-1:0]     r_fail_code;
  logic [31:0]          r_cycle_count;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_detect;
  logic [ADDR_BITS-1:0] w_byte_addr;
  logic [7:0]           w_byte;

  // A new word may enter when the buffer is empty or is emitting its last byte.
  assign w_in_ready  = (r_state == S_LOAD) && (r_words_acc < r_num_words) &&
                       (!r_buf_valid || (r_byte_idx == 2'd3));
  assign w_accept    = w_in_ready && bus.in_valid;
  // A stale END_A7 left in the core registers is ignored until a7 has moved away.
  assign w_detect    = r_armed && (bus.a7 == LP_END);
  // 4*word + byte is just the concatenation; truncation gives the address wrap.
  assign w_byte_addr = LP_BASE + {r_word_idx, r_byte_idx};
  assign w_byte      = r_buf[{r_byte_idx, 3'b000} +: 8];

  assign bus.in_ready    = w_in_ready;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data    = r_mem_data;
  assign bus.cpu_reset   = (r_state != S_RUN);
  assign bus.busy        = (r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.pass        = r_pass;
  assign bus.timeout     = r_timeout;
  assign bus.fail_code   = r_fail_code;
  assign bus.cycle_count = r_cycle_count;

  // Sequencer FSM: load, settle, run and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_num_words   <= '0;
      r_words_acc   <= '0;
      r_word_idx    <= '0;
      r_byte_idx    <= '0;
      r_buf         <= '0;
      r_buf_valid   <= 1'b0;
      r_settle_cnt  <= 1'b0;
      r_armed       <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_code   <= '0;
      r_cycle_count <= '0;
    end else if (bus.abort) begin
      r_state       <= S_IDLE;
      r_buf_valid   <= 1'b0;
      r_byte_idx    <= '0;
      r_armed       <= 1'b0;
      r_mem_en      <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_code   <= '0;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_mem_en <= 1'b0;
          if (bus.start) begin
            r_num_words   <= bus.num_words;
            r_words_acc   <= '0;
            r_word_idx    <= '0;
            r_byte_idx    <= '0;
            r_buf_valid   <= 1'b0;
            r_settle_cnt  <= 1'b0;
            r_armed       <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fail_code   <= '0;
            r_cycle_count <= '0;
            r_state       <= (bus.num_words == '0) ? S_SETTLE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_buf_valid) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= {{(WIDTH-ADDR_BITS){1'b0}}, w_byte_addr};
            r_mem_data <= {{(WIDTH-8){1'b0}}, w_byte};
            r_byte_idx <= r_byte_idx + 1'b1;
            if (r_byte_idx == 2'd3) begin
              r_word_idx  <= r_word_idx + 1'b1;
              r_buf_valid <= 1'b0;
            end
          end else begin
            r_mem_en <= 1'b0;
          end
          if (w_accept) begin
            r_buf       <= bus.in_data;
            r_buf_valid <= 1'b1;
            r_byte_idx  <= '0;
            r_words_acc <= r_words_acc + 1'b1;
          end
          // Leave only once the last byte cycle has been presented to the core.
          if (!r_buf_valid && (r_words_acc == r_num_words)) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_mem_en      <= 1'b0;
          r_cycle_count <= '0;
          r_armed       <= 1'b0;
          r_settle_cnt  <= 1'b1;
          if (r_settle_cnt) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_cycle_count <= r_cycle_count + 32'd1;
          r_armed       <= r_armed | (bus.a7 != LP_END);
          if (w_detect) begin
            r_fail_code <= bus.gp;
            r_pass      <= (bus.gp == WIDTH'(1)) && (bus.a0 == '0);
            r_timeout   <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_cycle_count == LP_LAST) begin
            r_fail_code <= bus.gp;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: two instances share the stimulus, one
// based at address 0 and one at 16380 to exercise the address wrap.
module tb_test_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [12:0] num_words = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] gp = '0;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  test_sequencer_if #(.WIDTH(32), .ADDR_BITS(14)) u_if0 ();
  test_sequencer_if #(.WIDTH(32), .ADDR_BITS(14)) u_if1 ();

  assign u_if0.start = start;     assign u_if1.start = start;
  assign u_if0.abort = abort;     assign u_if1.abort = abort;
  assign u_if0.num_words = num_words; assign u_if1.num_words = num_words;
  assign u_if0.in_valid = in_valid;   assign u_if1.in_valid = in_valid;
  assign u_if0.in_data = in_data; assign u_if1.in_data = in_data;
  assign u_if0.gp = gp;           assign u_if1.gp = gp;
  assign u_if0.a7 = a7;           assign u_if1.a7 = a7;
  assign u_if0.a0 = a0;           assign u_if1.a0 = a0;

  test_sequencer #(.WIDTH(32), .ADDR_BITS(14), .BASE_ADDR(0), .END_A7(93), .MAX_CYCLES(16))
    u_dut0 (.clock(clock), .reset(reset), .bus(u_if0.slave));
  test_sequencer #(.WIDTH(32), .ADDR_BITS(14), .BASE_ADDR(16380), .END_A7(93), .MAX_CYCLES(16))
    u_dut1 (.clock(clock), .reset(reset), .bus(u_if1.slave));

  // captured memory writes and timing marks
  logic [31:0] q0_addr[$];
  logic [31:0] q0_data[$];
  logic [31:0] q1_addr[$];
  int          cyc = 0;
  int          last_mem_cyc = 0;
  int          fall_cyc = 0;
  logic        prev_cr = 1'b1;

  logic [31:0] words[4];
  logic [31:0] s_a7[16];
  logic [31:0] s_gp[16];
  logic [31:0] s_a0[16];
  logic [7:0]  exp_bytes[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // monitor samples 1ns after each rising edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (u_if0.mem_en) begin
        q0_addr.push_back(u_if0.mem_addr);
        q0_data.push_back(u_if0.mem_data);
        last_mem_cyc = cyc;
      end
      if (u_if1.mem_en) q1_addr.push_back(u_if1.mem_addr);
      if (prev_cr && !u_if0.cpu_reset) fall_cyc = cyc;
      prev_cr = u_if0.cpu_reset;
    end
  end

  task automatic clear_q();
    q0_addr.delete();
    q0_data.delete();
    q1_addr.delete();
  endtask

  task automatic do_start(input int n);
    @(negedge clock);
    num_words = 13'(n);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int idx = 0;
    int c = 0;
    bit acc;
    while (idx < n && c < 200) begin
      in_data  = words[idx];
      in_valid = toggle ? ((c % 2) == 0) : 1'b1;
      acc = in_valid && u_if0.in_ready;
      @(negedge clock);
      if (acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    check("feed_words_accepted", 32'(idx), 32'(n));
  endtask

  task automatic wait_run();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!u_if0.cpu_reset) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("run_reached", {31'b0, ok}, 32'd1);
  endtask

  task automatic run_cycles(input int n, input string tag);
    bit early = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (u_if0.done) early = 1'b1;
      a7 = s_a7[i];
      gp = s_gp[i];
      a0 = s_a0[i];
      @(negedge clock);
    end
    check({tag, "_no_early_done"}, {31'b0, early}, 32'd0);
  endtask

  task automatic check_image(input string tag);
    logic [31:0] oa, od, ob;
    check({tag, "_count"}, 32'(q0_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      oa = (i < q0_addr.size()) ? q0_addr[i] : 32'hFFFF_FFFF;
      od = (i < q0_data.size()) ? q0_data[i] : 32'hFFFF_FFFF;
      ob = (i < q1_addr.size()) ? q1_addr[i] : 32'hFFFF_FFFF;
      check($sformatf("%s_addr%0d", tag, i), oa, 32'(i));
      check($sformatf("%s_data%0d", tag, i), od, {24'b0, exp_bytes[i]});
      check($sformatf("%s_wrap_addr%0d", tag, i), ob, 32'((16380 + i) % 16384));
    end
    check({tag, "_settle_gap"}, 32'(fall_cyc - last_mem_cyc), 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    check("rst_mem_en", {31'b0, u_if0.mem_en}, 32'd0);
    check("rst_mem_addr", u_if0.mem_addr, 32'd0);
    check("rst_mem_data", u_if0.mem_data, 32'd0);
    check("rst_in_ready", {31'b0, u_if0.in_ready}, 32'd0);
    check("rst_busy", {31'b0, u_if0.busy}, 32'd0);
    check("rst_done", {31'b0, u_if0.done}, 32'd0);
    check("rst_pass", {31'b0, u_if0.pass}, 32'd0);
    check("rst_timeout", {31'b0, u_if0.timeout}, 32'd0);
    check("rst_fail_code", u_if0.fail_code, 32'd0);
    check("rst_cycle_count", u_if0.cycle_count, 32'd0);
    check("rst_cpu_reset", {31'b0, u_if0.cpu_reset}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // two-word load, stale a7=93 held across load
    a7 = 32'd93;
    words[0] = 32'h0000_0013;
    words[1] = 32'h1234_5678;
    exp_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_q();
    do_start(2);
    check("in_ready_after_start", {31'b0, u_if0.in_ready}, 32'd1);
    check("busy_in_load", {31'b0, u_if0.busy}, 32'd1);
    feed(2, 1'b0);
    wait_run();
    check_image("load2");

    // stale marker, then 0 for 3 cycles, then marker with gp=1 a0=0
    s_a7[0:5] = '{32'd93, 32'd93, 32'd0, 32'd0, 32'd0, 32'd93};
    s_gp[0:5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    s_a0[0:5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_cycles(6, "stale");
    check("stale_done", {31'b0, u_if0.done}, 32'd1);
    check("stale_pass", {31'b0, u_if0.pass}, 32'd1);
    check("stale_fail_code", u_if0.fail_code, 32'd1);
    check("stale_timeout", {31'b0, u_if0.timeout}, 32'd0);
    check("stale_cycle_count", u_if0.cycle_count, 32'd6);
    check("stale_cpu_reset", {31'b0, u_if0.cpu_reset}, 32'd1);
    check("stale_busy", {31'b0, u_if0.busy}, 32'd0);
    check("stale_dut1_done", {31'b0, u_if1.done}, 32'd1);

    // failing end: gp=7 a0=7; restart from DONE with empty image
    do_start(0);
    check("restart_clear_pass", {31'b0, u_if0.pass}, 32'd0);
    check("restart_clear_fail_code", u_if0.fail_code, 32'd0);
    check("restart_clear_count", u_if0.cycle_count, 32'd0);
    check("restart_done_low", {31'b0, u_if0.done}, 32'd0);
    check("restart_busy", {31'b0, u_if0.busy}, 32'd1);
    wait_run();
    s_a7[0:1] = '{32'd0, 32'd93};
    s_gp[0:1] = '{32'd7, 32'd7};
    s_a0[0:1] = '{32'd7, 32'd7};
    run_cycles(2, "gp7");
    check("gp7_done", {31'b0, u_if0.done}, 32'd1);
    check("gp7_pass", {31'b0, u_if0.pass}, 32'd0);
    check("gp7_fail_code", u_if0.fail_code, 32'd7);
    check("gp7_timeout", {31'b0, u_if0.timeout}, 32'd0);
    check("gp7_cycle_count", u_if0.cycle_count, 32'd2);
    check("gp7_no_mem_writes", 32'(q0_addr.size()), 32'd8);

    // timeout with a7 never 93
    do_start(0);
    wait_run();
    for (int i = 0; i < 16; i++) begin
      s_a7[i] = 32'd0;
      s_gp[i] = 32'd5;
      s_a0[i] = 32'd0;
    end
    run_cycles(16, "tmo");
    check("tmo_done", {31'b0, u_if0.done}, 32'd1);
    check("tmo_timeout", {31'b0, u_if0.timeout}, 32'd1);
    check("tmo_pass", {31'b0, u_if0.pass}, 32'd0);
    check("tmo_cycle_count", u_if0.cycle_count, 32'd16);
    check("tmo_fail_code", u_if0.fail_code, 32'd5);

    // detection on the same cycle as the timeout
    do_start(0);
    wait_run();
    s_a7[15] = 32'd93;
    s_gp[15] = 32'd1;
    run_cycles(16, "tie");
    check("tie_done", {31'b0, u_if0.done}, 32'd1);
    check("tie_timeout", {31'b0, u_if0.timeout}, 32'd0);
    check("tie_pass", {31'b0, u_if0.pass}, 32'd1);
    check("tie_fail_code", u_if0.fail_code, 32'd1);
    check("tie_cycle_count", u_if0.cycle_count, 32'd16);

    // load with in_valid toggling every other cycle
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h0BAD_F00D;
    exp_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    clear_q();
    do_start(2);
    feed(2, 1'b1);
    wait_run();
    check_image("toggle");
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_run_busy", {31'b0, u_if0.busy}, 32'd0);
    check("abort_run_count", u_if0.cycle_count, 32'd0);

    // abort after five bytes, then restart with zero words
    clear_q();
    do_start(3);
    in_data  = 32'hAABB_CCDD;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q0_addr.size() >= 5) break;
      @(negedge clock);
    end
    check("abort_bytes_seen", 32'(q0_addr.size()), 32'd5);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_mem_en", {31'b0, u_if0.mem_en}, 32'd0);
    check("abort_busy", {31'b0, u_if0.busy}, 32'd0);
    check("abort_in_ready", {31'b0, u_if0.in_ready}, 32'd0);
    check("abort_cpu_reset", {31'b0, u_if0.cpu_reset}, 32'd1);
    check("abort_last_addr", (q0_addr.size() >= 5) ? q0_addr[4] : 32'hFFFF_FFFF, 32'd4);
    check("abort_wrap_addr", (q1_addr.size() >= 5) ? q1_addr[4] : 32'hFFFF_FFFF, 32'd0);
    do_start(0);
    check("zero_settle1_busy", {31'b0, u_if0.busy}, 32'd1);
    check("zero_settle1_cpu_reset", {31'b0, u_if0.cpu_reset}, 32'd1);
    @(negedge clock);
    check("zero_settle2_cpu_reset", {31'b0, u_if0.cpu_reset}, 32'd1);
    @(negedge clock);
    check("zero_run_cpu_reset", {31'b0, u_if0.cpu_reset}, 32'd0);
    check("zero_no_new_writes", 32'(q0_addr.size()), 32'd5);

    // asynchronous reset mid-RUN
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'b0, u_if0.busy}, 32'd0);
    check("midrst_cpu_reset", {31'b0, u_if0.cpu_reset}, 32'd1);
    check("midrst_cycle_count", u_if0.cycle_count, 32'd0);
    check("midrst_mem_en", {31'b0, u_if0.mem_en}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
